// File: rtl/tick_timer16_if.sv
// Register bus between the CPU and the tick timer: write strobe, address,
// write data and the registered read data.
interface tick_timer16_if #(
    parameter int WIDTH = 16
);
    logic             wr_en;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (
        output wr_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/tick_timer16.sv
// Timer_A style 16-bit timer that advances on an external tick strobe, with
// stop/up/continuous/up-down modes and a level interrupt on period events.
module tick_timer16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    tick_timer16_if.slave        bus,
    output logic [WIDTH-1:0]     cnt,
    output logic                 irq
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] ccr0_reg, ccr0_next;
    logic [1:0]       mc_reg, mc_next;
    logic             ie_reg, ie_next;
    logic             ifg_reg, ifg_next;
    logic             dir_reg, dir_next;
    logic [WIDTH-1:0] rdata_reg, rdata_next;
    logic [WIDTH-1:0] ctl_word;
    logic             hw_ifg;
    logic             ctl_wr;

    assign ctl_wr = bus.wr_en && (bus.addr == 2'd0);

    // CTL read view; CLR and the upper bits always read back as zero.
    assign ctl_word[1:0] = mc_reg;
    assign ctl_word[2]   = 1'b0;
    assign ctl_word[3]   = ie_reg;
    assign ctl_word[4]   = ifg_reg;
    assign ctl_word[5]   = dir_reg;
    generate
        for (genvar gi = 6; gi < WIDTH; gi++) begin : g_ctl_pad
            assign ctl_word[gi] = 1'b0;
        end
    endgenerate

    always_comb begin
        cnt_next  = cnt_reg;
        dir_next  = dir_reg;
        ccr0_next = ccr0_reg;
        mc_next   = mc_reg;
        ie_next   = ie_reg;
        hw_ifg    = 1'b0;

        // Tick-driven update always uses the MC value held before any write.
        if (tick) begin
            case (mc_reg)
                2'b01: begin
                    if (cnt_reg >= ccr0_reg) begin
                        cnt_next = '0;
                        hw_ifg   = (cnt_reg != '0);
                    end else begin
                        cnt_next = cnt_reg + ONE;
                    end
                end
                2'b10: begin
                    cnt_next = cnt_reg + ONE;
                    hw_ifg   = (cnt_reg == '1);
                end
                2'b11: begin
                    if (!dir_reg) begin
                        if (cnt_reg >= ccr0_reg) begin
                            // cnt=0 here means CCR0=0: the halt condition.
                            if (cnt_reg != '0) begin
                                dir_next = 1'b1;
                                cnt_next = cnt_reg - ONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + ONE;
                        end
                    end else if (cnt_reg == ONE) begin
                        cnt_next = '0;
                        dir_next = 1'b0;
                        hw_ifg   = 1'b1;
                    end else if (cnt_reg == '0) begin
                        cnt_next = ONE;
                        dir_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - ONE;
                    end
                end
                default: ;
            endcase
        end

        if (bus.wr_en) begin
            case (bus.addr)
                2'd0: begin
                    mc_next = bus.wdata[1:0];
                    ie_next = bus.wdata[3];
                    if (bus.wdata[2]) begin
                        cnt_next = '0;
                        dir_next = 1'b0;
                    end
                end
                2'd1: cnt_next  = bus.wdata;
                2'd2: ccr0_next = bus.wdata;
                default: ;
            endcase
        end

        // A hardware period event beats a software clear in the same cycle.
        if (hw_ifg)
            ifg_next = 1'b1;
        else if (ctl_wr)
            ifg_next = bus.wdata[4];
        else
            ifg_next = ifg_reg;

        case (bus.addr)
            2'd0:    rdata_next = ctl_word;
            2'd1:    rdata_next = cnt_reg;
            2'd2:    rdata_next = ccr0_reg;
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            ccr0_reg  <= '0;
            mc_reg    <= 2'b00;
            ie_reg    <= 1'b0;
            ifg_reg   <= 1'b0;
            dir_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            ccr0_reg  <= ccr0_next;
            mc_reg    <= mc_next;
            ie_reg    <= ie_next;
            ifg_reg   <= ifg_next;
            dir_reg   <= dir_next;
            rdata_reg <= rdata_next;
        end
    end

    assign bus.rdata = rdata_reg;
    assign cnt       = cnt_reg;
    assign irq       = ifg_reg & ie_reg;
endmodule

// File: tb/tb_tick_timer16.sv
// Directed bench for tick_timer16: each task drives one scenario and checks
// hand-computed counter, flag and read-back values.
module tb_tick_timer16;
    logic        clk;
    logic        rst;
    logic        tick;
    logic [15:0] cnt;
    logic        irq;
    int          tests_run;
    int          tests_failed;

    tick_timer16_if #(.WIDTH(16)) bus ();

    tick_timer16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .bus  (bus),
        .cnt  (cnt),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        $display("[TB] write addr=%0d data=%04h cnt=%04h", a, d, cnt);
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        bus.addr = a;
        @(posedge clk); #1;
        v = bus.rdata;
        $display("[TB] read  addr=%0d data=%04h", a, v);
    endtask

    // One tick pulse followed by 7 idle clocks (divide-by-8 cadence).
    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        $display("[TB] tick  cnt=%04h irq=%0b", cnt, irq);
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1; tick = 1'b0;
        bus.wr_en = 1'b0; bus.addr = 2'd0; bus.wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (cnt !== 16'h0000 || irq !== 1'b0 || bus.rdata !== 16'h0000) begin
            $display("FAIL reset_outputs: cnt=%04h irq=%0b rdata=%04h required 0000/0/0000", cnt, irq, bus.rdata);
            tests_failed++;
        end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], v);
            tests_run++;
            if (v !== 16'h0000) begin
                $display("FAIL reset_reg%0d: got %04h required 0000", a, v);
                tests_failed++;
            end
        end
        wr(2'd3, 16'hFFFF);
        rd(2'd3, v);
        tests_run++;
        if (v !== 16'h0000) begin
            $display("FAIL reserved_read: got %04h required 0000", v);
            tests_failed++;
        end
    endtask

    task automatic test_up_mode();
        logic [15:0] v;
        logic [15:0] exp_cnt [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        logic        exp_ifg [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr(2'd2, 16'd3);
        wr(2'd0, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            do_tick();
            rd(2'd0, v);
            tests_run++;
            if (cnt !== exp_cnt[i] || v[4] !== exp_ifg[i] || irq !== 1'b0) begin
                $display("FAIL up_step%0d: cnt=%04h ifg=%0b irq=%0b required %04h/%0b/0", i, cnt, v[4], irq, exp_cnt[i], exp_ifg[i]);
                tests_failed++;
            end
        end
        wr(2'd0, 16'h0019);
        tests_run++;
        if (irq !== 1'b1) begin
            $display("FAIL up_irq_enable: irq=%0b required 1", irq);
            tests_failed++;
        end
        wr(2'd0, 16'h0004);
    endtask

    task automatic test_updown();
        logic [15:0] v;
        logic [15:0] exp_cnt [8] = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
        logic        exp_dir [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_ifg [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        wr(2'd2, 16'd2);
        wr(2'd0, 16'h0007);
        for (int i = 0; i < 8; i++) begin
            do_tick();
            rd(2'd0, v);
            tests_run++;
            if (cnt !== exp_cnt[i] || v[5] !== exp_dir[i] || v[4] !== exp_ifg[i]) begin
                $display("FAIL updown_step%0d: cnt=%04h dir=%0b ifg=%0b required %04h/%0b/%0b", i, cnt, v[5], v[4], exp_cnt[i], exp_dir[i], exp_ifg[i]);
                tests_failed++;
            end
            if (i == 3) wr(2'd0, 16'h0003);
        end
        wr(2'd0, 16'h0004);
    endtask

    task automatic test_continuous();
        logic [15:0] v;
        wr(2'd0, 16'h0006);
        wr(2'd1, 16'hFFFE);
        do_tick();
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'hFFFF || v[4] !== 1'b0) begin
            $display("FAIL cont_ffff: cnt=%04h ifg=%0b required ffff/0", cnt, v[4]);
            tests_failed++;
        end
        do_tick();
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'h0000 || v[4] !== 1'b1) begin
            $display("FAIL cont_wrap: cnt=%04h ifg=%0b required 0000/1", cnt, v[4]);
            tests_failed++;
        end
        wr(2'd0, 16'h0004);
    endtask

    task automatic test_collision();
        logic [15:0] v;
        wr(2'd2, 16'h0100);
        wr(2'd0, 16'h0005);
        do_tick();
        do_tick();
        // CNT write and tick on the same edge: written value wins.
        tick = 1'b1;
        wr(2'd1, 16'h0010);
        tick = 1'b0;
        tests_run++;
        if (cnt !== 16'h0010) begin
            $display("FAIL collision_cnt: cnt=%04h required 0010", cnt);
            tests_failed++;
        end
        wr(2'd2, 16'h0010);
        // Hardware IFG set against a software IFG=0 write.
        tick = 1'b1;
        wr(2'd0, 16'h0001);
        tick = 1'b0;
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'h0000 || v[4] !== 1'b1) begin
            $display("FAIL collision_ifg: cnt=%04h ifg=%0b required 0000/1", cnt, v[4]);
            tests_failed++;
        end
        // MC change on a tick cycle: tick uses old MC (up), so it still counts.
        tick = 1'b1;
        wr(2'd0, 16'h0000);
        tick = 1'b0;
        tests_run++;
        if (cnt !== 16'h0001) begin
            $display("FAIL mc_change_to_stop: cnt=%04h required 0001", cnt);
            tests_failed++;
        end
        // Old MC is stop, so this tick is ignored.
        tick = 1'b1;
        wr(2'd0, 16'h0001);
        tick = 1'b0;
        tests_run++;
        if (cnt !== 16'h0001) begin
            $display("FAIL mc_change_to_up: cnt=%04h required 0001", cnt);
            tests_failed++;
        end
        wr(2'd0, 16'h0004);
    endtask

    task automatic test_halt_late_ccr0();
        logic [15:0] v;
        wr(2'd2, 16'h0000);
        wr(2'd0, 16'h0005);
        do_tick();
        do_tick();
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'h0000 || v[4] !== 1'b0) begin
            $display("FAIL halt: cnt=%04h ifg=%0b required 0000/0", cnt, v[4]);
            tests_failed++;
        end
        wr(2'd1, 16'd10);
        wr(2'd2, 16'd5);
        do_tick();
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'h0000 || v[4] !== 1'b1) begin
            $display("FAIL late_ccr0: cnt=%04h ifg=%0b required 0000/1", cnt, v[4]);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] v;
        wr(2'd2, 16'h0100);
        wr(2'd0, 16'h001D);
        wr(2'd1, 16'h0042);
        bus.addr = 2'd1;
        @(posedge clk); #1;
        tests_run++;
        if (cnt !== 16'h0042 || irq !== 1'b1 || bus.rdata !== 16'h0042) begin
            $display("FAIL pre_reset: cnt=%04h irq=%0b rdata=%04h required 0042/1/0042", cnt, irq, bus.rdata);
            tests_failed++;
        end
        rst = 1'b1; tick = 1'b1;
        bus.wr_en = 1'b1; bus.addr = 2'd1; bus.wdata = 16'h1234;
        @(posedge clk); #1;
        rst = 1'b0; tick = 1'b0; bus.wr_en = 1'b0;
        tests_run++;
        if (cnt !== 16'h0000 || irq !== 1'b0 || bus.rdata !== 16'h0000) begin
            $display("FAIL mid_reset: cnt=%04h irq=%0b rdata=%04h required 0000/0/0000", cnt, irq, bus.rdata);
            tests_failed++;
        end
        do_tick();
        do_tick();
        rd(2'd0, v);
        tests_run++;
        if (cnt !== 16'h0000 || v !== 16'h0000) begin
            $display("FAIL post_reset_idle: cnt=%04h ctl=%04h required 0000/0000", cnt, v);
            tests_failed++;
        end
        rd(2'd2, v);
        tests_run++;
        if (v !== 16'h0000) begin
            $display("FAIL post_reset_ccr0: got %04h required 0000", v);
            tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_up_mode();
        test_updown();
        test_continuous();
        test_collision();
        test_halt_late_ccr0();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/tick_timer16.md
Name: tick_timer16

Overview:
- 16-bit timer peripheral, MSP430 Timer_A flavour, driven by a periodic count-enable strobe.
- It sits downstream of the divide-by-8 tick generator and consumes its one-cycle `tick` pulse as the count enable. It does not count raw clocks.
- The CPU programs it through a small register port.
- It raises a level interrupt on period events.

Parameters:
- WIDTH, 16, counter / CCR0 / data width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  count-enable strobe, one clk wide; counter advances only on cycles where tick=1
- wr_en  in  1  register write strobe
- addr  in  2  register select: 0=CTL, 1=CNT, 2=CCR0, 3=reserved (writes ignored, reads 0)
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  registered read data of register at addr
- cnt  out  WIDTH  live counter value
- irq  out  1  interrupt request = IFG & IE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: cnt=0, CCR0=0, MC=00, IE=0, IFG=0, DIR=0, rdata=0, irq=0.
- CTL layout:
  - [1:0] MC mode: 00 stop, 01 up, 10 continuous, 11 up/down
  - [2] CLR: write-only, self-clearing, reads 0
  - [3] IE
  - [4] IFG
  - [5] DIR: read-only, 0=up, 1=down
  - [15:6] read 0
- Writes:
  - Take effect at the next rising edge.
  - A CTL write loads MC, IE and IFG from wdata.
  - If the CTL write has CLR=1, it also sets cnt=0 and DIR=0.
- Read port:
  - rdata <= register[addr] every cycle, unconditionally.
  - Latency is one cycle; reads have no side effects.
- Counting occurs only when tick=1 and MC!=00. In stop mode (MC=00), cnt and DIR hold.
- Up mode (01):
  - If cnt>=CCR0: cnt<=0 and IFG<=1.
  - Else: cnt<=cnt+1.
  - CCR0=0 with cnt=0: counter holds at 0 and IFG is not set. This is the halt condition.
- Continuous mode (10):
  - cnt<=cnt+1 with modulo-2^WIDTH wrap.
  - IFG<=1 on the 0xFFFF->0 transition. CCR0 is ignored.
- Up/down mode (11):
  - DIR=0, cnt>=CCR0: DIR<=1, cnt<=cnt-1.
  - DIR=0, otherwise: cnt<=cnt+1.
  - DIR=1, cnt==1: cnt<=0, IFG<=1, DIR<=0.
  - DIR=1, cnt==0: DIR<=0, cnt<=1. This case is only reachable via a CNT write.
  - DIR=1, otherwise: cnt<=cnt-1.
  - Period is 2*CCR0 ticks. CCR0=0 with cnt=0 halts, with no IFG.
- Priority in the same cycle:
  - A CNT write or CLR=1 overrides any tick-driven cnt/DIR update; the written value wins.
  - A CTL write changing MC does not suppress that cycle's tick. The tick is evaluated with the pre-write MC.
  - A hardware IFG set wins over a software write of IFG=0 in the same cycle.
  - A software write of IFG=1 sets the flag (software-triggered interrupt).
- A CCR0 write takes effect for comparisons from the next cycle onward.
- irq is combinational from the IFG and IE registers, so it is asserted the cycle after IFG is set.
- Reset asserted mid-count returns all state to reset values on that edge, regardless of tick or wr_en.

Test Plan:
- Up mode: CCR0=3, MC=01, tick every 8 clk.
  - Required: cnt sequence 0,1,2,3,0,1…
  - IFG rises on the 3->0 tick; irq=1 only after IE=1 is written.
- Up/down mode: CCR0=2, MC=11.
  - Required: cnt 0,1,2,1,0,1,2…
  - DIR=1 after reaching 2; IFG set on the 1->0 step; period is 4 ticks.
- Continuous wrap: CNT write 0xFFFE, MC=10.
  - Required: two ticks give 0xFFFF then 0x0000; IFG set exactly at the wrap.
- Collision: CNT write 0x0010 in the same cycle as tick=1 in up mode.
  - Required: cnt=0x0010 next cycle, not an increment.
  - Hardware IFG set coinciding with a CTL write of IFG=0 -> IFG stays 1.
- Halt / late CCR0: up mode with CCR0=0 -> cnt holds 0, IFG stays 0.
  - Then cnt=10 and CCR0 written to 5 -> next tick gives cnt=0 and IFG=1.
- Reset mid-run: assert rst while cnt=0x0042, MC=01, IFG=1.
  - Required: all registers 0 and rdata=0 on the next edge; no counting until MC is rewritten.
